instr_encoder: RTL and testbench

Packs a decoded LEGv8 operation (op select, register numbers, immediate value) back into a 32-bit instruction word. It is the encoding counterpart of the decode-stage immediate extraction, and is used by the boot/program loader and the self-test generator to write instruction memory. Requests pass through an input register stage into a small output FIFO under valid/ready handshakes on both sides. Each emitted word is tagged with its instruction-memory address. Malformed requests are flagged and counted.

---
 rtl/instr_encoder.sv | 135 +++++++++++++
 tb/tb_instr_encoder.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// LEGv8 instruction encoder: one input register stage (S1), encode/range-check on S1,
// then a small output FIFO tagging each word with its instruction-memory address.
module instr_encoder #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [63:0] BASE_ADDR  = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_op,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rn,
  input  logic [63:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [63:0] out_addr,
  output logic        out_err,
  output logic [15:0] err_count
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  localparam logic [3:0] OP_ADDI = 4'd0;
  localparam logic [3:0] OP_ANDI = 4'd1;
  localparam logic [3:0] OP_EORI = 4'd2;
  localparam logic [3:0] OP_ORRI = 4'd3;
  localparam logic [3:0] OP_SUBI = 4'd4;
  localparam logic [3:0] OP_LDUR = 4'd5;
  localparam logic [3:0] OP_STUR = 4'd6;
  localparam logic [3:0] OP_CBZ  = 4'd7;
  localparam logic [3:0] OP_B    = 4'd8;

  logic          s1_valid;
  logic [3:0]    s1_op;
  logic [4:0]    s1_rd;
  logic [4:0]    s1_rn;
  logic [63:0]   s1_imm;

  logic [31:0]   enc_instr;
  logic          enc_ok;

  logic [31:0]   mem_instr [FIFO_DEPTH];
  logic [63:0]   mem_addr  [FIFO_DEPTH];
  logic          mem_err   [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] fifo_count;
  logic [63:0]   addr_cnt;

  logic          accept;
  logic          push;
  logic          pop;

  // Legal when every bit above the field's sign bit matches that sign bit.
  function automatic logic fits(input logic [63:0] imm, input int unsigned sign_bit);
    logic [63:0] hi;
    hi = $signed(imm) >>> sign_bit;
    return (hi == '0) || (hi == '1);
  endfunction

  always_comb begin
    enc_instr = '0;
    enc_ok    = 1'b0;
    case (s1_op)
      OP_ADDI: begin enc_instr = {10'b1001000100, s1_imm[11:0], s1_rn, s1_rd}; enc_ok = fits(s1_imm, 11); end
      OP_ANDI: begin enc_instr = {10'b1001001000, s1_imm[11:0], s1_rn, s1_rd}; enc_ok = fits(s1_imm, 11); end
      OP_EORI: begin enc_instr = {10'b1101001000, s1_imm[11:0], s1_rn, s1_rd}; enc_ok = fits(s1_imm, 11); end
      OP_ORRI: begin enc_instr = {10'b1011001000, s1_imm[11:0], s1_rn, s1_rd}; enc_ok = fits(s1_imm, 11); end
      OP_SUBI: begin enc_instr = {10'b1101000100, s1_imm[11:0], s1_rn, s1_rd}; enc_ok = fits(s1_imm, 11); end
      OP_LDUR: begin enc_instr = {11'b11111000010, s1_imm[8:0], 2'b00, s1_rn, s1_rd}; enc_ok = fits(s1_imm, 8); end
      OP_STUR: begin enc_instr = {11'b11111000000, s1_imm[8:0], 2'b00, s1_rn, s1_rd}; enc_ok = fits(s1_imm, 8); end
      OP_CBZ:  begin enc_instr = {8'b10110100, s1_imm[18:0], s1_rd}; enc_ok = fits(s1_imm, 18); end
      OP_B:    begin enc_instr = {6'b000101, s1_imm[25:0]}; enc_ok = fits(s1_imm, 25); end
      default: begin enc_instr = '0; enc_ok = 1'b0; end
    endcase
    if (!enc_ok) enc_instr = '0;
  end

  // S1 reserves a FIFO slot, so a registered S1 can always push on the next edge.
  assign in_ready  = (32'(fifo_count) + 32'(s1_valid)) < 32'(FIFO_DEPTH);
  assign accept    = in_valid && in_ready;
  assign push      = s1_valid;
  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid && out_ready;

  assign out_instr = mem_instr[rd_ptr];
  assign out_addr  = mem_addr[rd_ptr];
  assign out_err   = mem_err[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid   <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      addr_cnt   <= BASE_ADDR;
      err_count  <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_instr[PW'(i)] <= '0;
        mem_addr[PW'(i)]  <= BASE_ADDR;
        mem_err[PW'(i)]   <= 1'b0;
      end
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_op  <= in_op;
        s1_rd  <= in_rd;
        s1_rn  <= in_rn;
        s1_imm <= in_imm;
      end

      if (push) begin
        mem_instr[wr_ptr] <= enc_instr;
        mem_addr[wr_ptr]  <= addr_cnt;
        mem_err[wr_ptr]   <= !enc_ok;
        wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
        if (enc_ok) begin
          addr_cnt <= addr_cnt + 64'd4;
        end else if (err_count != '1) begin
          err_count <= err_count + 16'd1;
        end
      end

      if (pop) begin
        rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end

      fifo_count <= fifo_count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: encodings, range errors, address wrap,
// backpressure, streaming round trip and mid-stream reset.
module tb_instr_encoder;

  localparam logic [63:0] BASE = 64'hFFFF_FFFF_FFFF_FFF0;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [4:0]  in_rd;
  logic [4:0]  in_rn;
  logic [63:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [63:0] out_addr;
  logic        out_err;
  logic [15:0] err_count;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_addr;
  int          exp_errs;

  typedef struct {
    logic [3:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rn;
    logic [63:0] imm;
    logic [31:0] instr;
    logic        err;
  } vec_t;

  typedef struct packed {
    logic [3:0]  op;
    logic [63:0] imm;
  } sent_t;

  vec_t  vecs[17];
  sent_t q[$];

  instr_encoder #(.FIFO_DEPTH(4), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rn(in_rn), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr), .out_err(out_err),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] sext(input logic [63:0] v, input int unsigned w);
    logic [63:0] t;
    t = v << (64 - w);
    return $signed(t) >>> (64 - w);
  endfunction

  // Presents a request from a negedge and returns at the negedge after it is accepted.
  task automatic put(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rn,
                     input logic [63:0] imm);
    logic acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    in_valid = 1'b1; in_op = op; in_rd = rd; in_rn = rn; in_imm = imm;
    while (!acc && n < 40) begin
      acc = in_ready;
      n++;
      @(posedge clk); @(negedge clk);
    end
    in_valid = 1'b0;
    chk("put_accept", 64'(acc), 64'd1);
  endtask

  task automatic take(input string tag, input logic [31:0] ei, input logic ee);
    int n;
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_instr"}, 64'(out_instr), 64'(ei));
    chk({tag, "_addr"}, out_addr, exp_addr);
    chk({tag, "_err"}, 64'(out_err), 64'(ee));
    if (ee) exp_errs++;
    else exp_addr = exp_addr + 64'd4;
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{4'd0,  5'd1,  5'd2,  64'hFFFF_FFFF_FFFF_FFFF, 32'h913FFC41, 1'b0};
    vecs[1]  = '{4'd5,  5'd3,  5'd4,  64'hFFFF_FFFF_FFFF_FFF8, 32'hF85F8083, 1'b0};
    vecs[2]  = '{4'd8,  5'd0,  5'd0,  64'h1,                   32'h14000001, 1'b0};
    vecs[3]  = '{4'd7,  5'd5,  5'd0,  64'hFFFF_FFFF_FFFF_FFFF, 32'hB4FFFFE5, 1'b0};
    vecs[4]  = '{4'd0,  5'd0,  5'd0,  64'h800,                 32'h0,        1'b1};
    vecs[5]  = '{4'd6,  5'd0,  5'd0,  64'hFFFF_FFFF_FFFF_FEFF, 32'h0,        1'b1};
    vecs[6]  = '{4'd12, 5'd0,  5'd0,  64'h0,                   32'h0,        1'b1};
    vecs[7]  = '{4'd0,  5'd0,  5'd0,  64'h0,                   32'h91000000, 1'b0};
    vecs[8]  = '{4'd4,  5'd31, 5'd31, 64'h7FF,                 32'hD11FFFFF, 1'b0};
    vecs[9]  = '{4'd0,  5'd0,  5'd0,  64'hFFFF_FFFF_FFFF_F800, 32'h91200000, 1'b0};
    vecs[10] = '{4'd6,  5'd7,  5'd8,  64'hFF,                  32'hF80FF107, 1'b0};
    vecs[11] = '{4'd7,  5'd0,  5'd0,  64'h40000,               32'h0,        1'b1};
    vecs[12] = '{4'd8,  5'd0,  5'd0,  64'hFFFF_FFFF_FE00_0000, 32'h16000000, 1'b0};
    vecs[13] = '{4'd1,  5'd2,  5'd3,  64'h5,                   32'h92001462, 1'b0};
    vecs[14] = '{4'd2,  5'd0,  5'd0,  64'h0,                   32'hD2000000, 1'b0};
    vecs[15] = '{4'd3,  5'd0,  5'd0,  64'h0,                   32'hB2000000, 1'b0};
    vecs[16] = '{4'd5,  5'd0,  5'd0,  64'h100,                 32'h0,        1'b1};

    // Reset
    reset = 1'b1; in_valid = 1'b0; in_op = '0; in_rd = '0; in_rn = '0; in_imm = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_err_count", 64'(err_count), 64'd0);
    chk("rst_out_instr", 64'(out_instr), 64'd0);
    chk("rst_out_addr", out_addr, BASE);
    chk("rst_out_err", 64'(out_err), 64'd0);
    reset = 1'b0;
    exp_addr = BASE;
    exp_errs = 0;

    // ADDI latency: valid appears two edges after acceptance
    in_valid = 1'b1; in_op = vecs[0].op; in_rd = vecs[0].rd; in_rn = vecs[0].rn; in_imm = vecs[0].imm;
    chk("lat_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    chk("lat_one_edge", 64'(out_valid), 64'd0);
    @(posedge clk); @(negedge clk);
    chk("lat_two_edges", 64'(out_valid), 64'd1);
    take("addi", vecs[0].instr, vecs[0].err);

    // Directed vectors in chunks of up to three, buffered then drained in order
    for (int unsigned base = 1; base < 17; base += 3) begin
      for (int unsigned k = base; k < base + 3 && k < 17; k++)
        put(vecs[k].op, vecs[k].rd, vecs[k].rn, vecs[k].imm);
      for (int unsigned k = base; k < base + 3 && k < 17; k++)
        take($sformatf("vec%0d", k), vecs[k].instr, vecs[k].err);
      chk("vec_err_count", 64'(err_count), 64'(exp_errs));
    end

    // Backpressure: out_ready low, stream ADDI rd=i imm=i
    begin
      int acc_n;
      acc_n = 0;
      for (int c = 0; c < 10; c++) begin
        in_valid = 1'b1; in_op = 4'd0; in_rd = 5'(acc_n); in_rn = 5'd0; in_imm = 64'(acc_n);
        if (in_ready) acc_n++;
        @(posedge clk); @(negedge clk);
      end
      in_valid = 1'b0;
      chk("bp_accepted", 64'(acc_n), 64'd4);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      repeat (3) @(negedge clk);
      chk("bp_hold_instr", 64'(out_instr), 64'h91000000);
      chk("bp_hold_addr", out_addr, exp_addr);
      chk("bp_hold_ready", 64'(in_ready), 64'd0);
      for (int unsigned i = 0; i < 4; i++)
        take($sformatf("bp%0d", i), 32'h91000000 | (i << 10) | i, 1'b0);
    end

    // Streaming: 100 random legal requests, one output per cycle
    out_ready = 1'b1;
    for (int i = 0; i < 102; i++) begin
      chk("stream_valid", 64'(out_valid), 64'(i >= 2));
      if (out_valid && q.size() > 0) begin
        sent_t s;
        logic [63:0] dec;
        s = q.pop_front();
        case (s.op)
          4'd5, 4'd6: dec = sext(64'(out_instr[20:12]), 9);
          4'd7:       dec = sext(64'(out_instr[23:5]), 19);
          4'd8:       dec = sext(64'(out_instr[25:0]), 26);
          default:    dec = sext(64'(out_instr[21:10]), 12);
        endcase
        chk("stream_roundtrip", dec, s.imm);
        chk("stream_addr", out_addr, exp_addr);
        chk("stream_err", 64'(out_err), 64'd0);
        exp_addr = exp_addr + 64'd4;
      end
      if (i < 100) begin
        sent_t s;
        logic [63:0] r;
        chk("stream_in_ready", 64'(in_ready), 64'd1);
        s.op = 4'($urandom_range(0, 8));
        r = {$urandom(), $urandom()};
        case (s.op)
          4'd5, 4'd6: s.imm = sext(r, 9);
          4'd7:       s.imm = sext(r, 19);
          4'd8:       s.imm = sext(r, 26);
          default:    s.imm = sext(r, 12);
        endcase
        q.push_back(s);
        in_valid = 1'b1; in_op = s.op; in_imm = s.imm;
        in_rd = 5'($urandom()); in_rn = 5'($urandom());
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); @(negedge clk);
    end
    out_ready = 1'b0;
    chk("stream_drained", 64'(q.size()), 64'd0);

    // Reset with three entries buffered and a request on the input
    put(4'd0, 5'd1, 5'd1, 64'd1);
    put(4'd0, 5'd2, 5'd2, 64'd2);
    put(4'd0, 5'd3, 5'd3, 64'd3);
    @(posedge clk); @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b1; in_op = 4'd0; in_imm = 64'd9;
    @(posedge clk); @(negedge clk);
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_err_count", 64'(err_count), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    reset = 1'b0;
    in_valid = 1'b0;
    exp_addr = BASE;
    exp_errs = 0;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    chk("post_rst_empty", 64'(out_valid), 64'd0);
    put(vecs[7].op, vecs[7].rd, vecs[7].rn, vecs[7].imm);
    take("post_rst", vecs[7].instr, vecs[7].err);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
